// File: rtl/cline_arbiter.sv
// cline_arbiter: N-channel cacheline arbiter in front of a single cacheline adaptor;
// grants one pmem read/write at a time (fixed priority or round-robin) and returns a registered response.
module cline_arbiter #(
    parameter int NUM_CH  = 2,
    parameter int LINE_W  = 256,
    parameter int ADDR_W  = 32,
    parameter int RR_MODE = 0,
    localparam int GW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
    input  logic [NUM_CH*LINE_W-1:0] ch_wdata,
    input  logic [NUM_CH-1:0]        ch_read,
    input  logic [NUM_CH-1:0]        ch_write,
    output logic [LINE_W-1:0]        ch_rdata,
    output logic [NUM_CH-1:0]        ch_resp,
    output logic [ADDR_W-1:0]        pmem_address,
    output logic [LINE_W-1:0]        pmem_wdata,
    output logic                     pmem_read,
    output logic                     pmem_write,
    input  logic [LINE_W-1:0]        pmem_rdata,
    input  logic                     pmem_resp,
    output logic [GW-1:0]            grant_id,
    output logic                     busy
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state, state_n;
    logic [NUM_CH-1:0] req;
    logic [GW-1:0] sel, base, idx, g_q, last;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] wdata_q, rdata_q;
    logic wr_q;
    assign req = ch_read | ch_write;
    // Search starts just after base; fixed priority is a rotation anchored at NUM_CH-1.
    always_comb begin
        base = (RR_MODE != 0) ? last : GW'(NUM_CH - 1);
        sel = '0;
        idx = '0;
        for (int k = NUM_CH; k >= 1; k--) begin
            idx = GW'((int'(base) + k) % NUM_CH);
            if (req[idx]) sel = idx;
        end
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else state <= state_n;
    end
    always_comb begin
        state_n = state;
        state_n = (state == IDLE) ? ((|req) ? BUSY : IDLE) :
                  (state == BUSY) ? (pmem_resp ? DONE : BUSY) : IDLE;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            g_q     <= '0;
            last    <= GW'(NUM_CH - 1);
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            rdata_q <= '0;
        end else begin
            if (state == IDLE && (|req)) begin
                g_q     <= sel;
                last    <= sel;
                addr_q  <= ch_addr[int'(sel)*ADDR_W +: ADDR_W];
                wdata_q <= ch_wdata[int'(sel)*LINE_W +: LINE_W];
                wr_q    <= ch_write[sel];
            end
            if (state == BUSY && pmem_resp && !wr_q) rdata_q <= pmem_rdata;
        end
    end
    assign busy         = state != IDLE;
    assign pmem_read    = (state == BUSY) && !wr_q;
    assign pmem_write   = (state == BUSY) && wr_q;
    assign pmem_address = addr_q;
    assign pmem_wdata   = wdata_q;
    assign ch_rdata     = rdata_q;
    assign ch_resp      = (state == DONE) ? (NUM_CH'(1) << g_q) : '0;
    assign grant_id     = busy ? g_q : '0;
endmodule
